// File: rtl/ks_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ks_addsub_pipe
// Brief    : Fully pipelined Kogge-Stone adder/subtractor with valid/ready
//            handshake, carry-out, signed overflow and zero flags.
//            Optional macro KS_ADDSUB_SAT_EN enables signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
module ks_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int LAT    = STAGES + 2;

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_raw;

  // Index 0 is the level-0 register, index s holds prefix level s.
  logic [STAGES:0][WIDTH-1:0]   g_q, g_d;
  logic [STAGES:0][WIDTH-1:0]   p0_q, p0_d;
  logic [STAGES-1:0][WIDTH-1:0] p_q, p_d;
  logic [STAGES:0]              c_q, c_d;
  logic [LAT-1:0]               v_q, v_d;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  always_comb begin
    en    = ~v_q[LAT-1] | out_ready;
    b_eff = sub ? ~b : b;
    c_eff = sub ? ~cin : cin;
    v_d   = {v_q[LAT-2:0], in_valid};

    g_d  = g_q;
    p_d  = p_q;
    p0_d = p0_q;
    c_d  = c_q;

    p_d[0]    = a ^ b_eff;
    g_d[0]    = a & b_eff;
    g_d[0][0] = (a[0] & b_eff[0]) | (c_eff & p_d[0][0]);
    p0_d[0]   = a ^ b_eff;
    c_d[0]    = c_eff;

    for (int s = 1; s <= STAGES; s++) begin
      p0_d[s] = p0_q[s-1];
      c_d[s]  = c_q[s-1];
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (s - 1))) begin
          g_d[s][i] = g_q[s-1][i] | (p_q[s-1][i] & g_q[s-1][i - (1 << (s - 1))]);
        end else begin
          g_d[s][i] = g_q[s-1][i];
        end
      end
    end

    // The last level only needs generate terms, so propagate stops one short.
    for (int s = 1; s < STAGES; s++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (s - 1))) begin
          p_d[s][i] = p_q[s-1][i] & p_q[s-1][i - (1 << (s - 1))];
        end else begin
          p_d[s][i] = p_q[s-1][i];
        end
      end
    end

    carry   = g_q[STAGES];
    sum_raw = p0_q[STAGES] ^ {carry[WIDTH-2:0], c_q[STAGES]};
    cout_d  = carry[WIDTH-1];
    ovf_d   = carry[WIDTH-2] ^ carry[WIDTH-1];
    sum_d   = sum_raw;
`ifdef KS_ADDSUB_SAT_EN
    // On overflow the operand sign is the inverse of the wrapped result sign.
    if (ovf_d) begin
      sum_d = sum_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
    zero_d = ~|sum_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      v_q    <= v_d;
      g_q    <= g_d;
      p_q    <= p_d;
      p0_q   <= p0_d;
      c_q    <= c_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v_q[LAT-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_ks_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ks_addsub_pipe
// Brief    : Scoreboard bench for ks_addsub_pipe at WIDTH 16, 13 and 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ks_addsub_pipe;

  localparam int NI   = 3;
  localparam int LAT0 = 6;
  localparam int NCYC = 10000;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  function automatic int width_of(input int k);
    case (k)
      0:       return 16;
      1:       return 13;
      default: return 2;
    endcase
  endfunction

  function automatic logic [15:0] mask16(input int k);
    return 16'((32'd1 << width_of(k)) - 32'd1);
  endfunction

  // Plain-integer reference: unsigned result for sum/cout, signed for ovf.
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub);
    exp_t   e;
    longint full = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint sa   = (a >= half) ? a - full : a;
    longint sb   = (b >= half) ? b - full : b;
    longint ures = sub ? a - b - longint'(cin) : a + b + longint'(cin);
    longint sres = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    longint r;
    e.cout = sub ? (ures >= 0) : (ures >= full);
    e.ovf  = (sres >= half) || (sres < -half);
    r      = ures & (full - 1);
`ifdef KS_ADDSUB_SAT_EN
    if (e.ovf) r = (sres >= 0) ? half - 1 : half;
`endif
    e.sum  = 16'(r);
    e.zero = (r == 0);
    return e;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_s [NI];
  logic [15:0] b_s [NI];
  logic        cin_s [NI];
  logic        sub_s [NI];
  logic        iv_s [NI];
  logic        or_s [NI];
  logic        ir_s [NI];
  logic        ov_s [NI];
  logic [15:0] sum_x [NI];
  logic        cout_x [NI];
  logic        ovf_x [NI];
  logic        zero_x [NI];

  int errors = 0;
  int checks = 0;
  bit end_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int W = width_of(k);
    logic         in_ready, out_valid, cout, ovf, zero;
    logic [W-1:0] sum;
    exp_t         q[$];
    exp_t         e;
    logic [W-1:0] held_sum;
    logic         held_c, held_o, held_z;
    bit           held = 1'b0;
    bit           end_done = 1'b0;

    ks_addsub_pipe #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv_s[k]),
      .in_ready  (in_ready),
      .a         (a_s[k][W-1:0]),
      .b         (b_s[k][W-1:0]),
      .cin       (cin_s[k]),
      .sub       (sub_s[k]),
      .out_valid (out_valid),
      .out_ready (or_s[k]),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
    );

    assign ir_s[k]   = in_ready;
    assign ov_s[k]   = out_valid;
    assign sum_x[k]  = 16'(sum);
    assign cout_x[k] = cout;
    assign ovf_x[k]  = ovf;
    assign zero_x[k] = zero;

    always @(negedge clk) begin : p_push
      if (rst) q.delete();
      else if (iv_s[k] && in_ready)
        q.push_back(model(W, longint'(a_s[k][W-1:0]), longint'(b_s[k][W-1:0]),
                          cin_s[k], sub_s[k]));
    end

    always @(negedge clk) begin : p_mon
      if (rst) begin
        held = 1'b0;
      end else begin
        checks++;
        if (in_ready !== (!out_valid || or_s[k])) begin
          errors++;
          $display("FAIL w%0d in_ready: got %b want %b", W, in_ready, !out_valid || or_s[k]);
        end
        if (held) begin
          checks++;
          if (out_valid !== 1'b1 || {sum, cout, ovf, zero} !== {held_sum, held_c, held_o, held_z}) begin
            errors++;
            $display("FAIL w%0d stall_hold: got v=%b sum=%h want v=1 sum=%h", W, out_valid,
                     16'(sum), 16'(held_sum));
          end
        end
        if (out_valid && or_s[k]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL w%0d unexpected_result: got sum=%h want no result", W, 16'(sum));
          end else begin
            e = q.pop_front();
            if (16'(sum) !== e.sum || cout !== e.cout || ovf !== e.ovf || zero !== e.zero) begin
              errors++;
              $display("FAIL w%0d result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                       W, 16'(sum), cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
            end
          end
        end
        held     = out_valid && !or_s[k];
        held_sum = sum;
        held_c   = cout;
        held_o   = ovf;
        held_z   = zero;
        if (end_chk && !end_done) begin
          end_done = 1'b1;
          checks++;
          if (q.size() != 0) begin
            errors++;
            $display("FAIL w%0d missing_results: got %0d outstanding want 0", W, q.size());
          end
        end
      end
    end
  end

  task automatic run_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo, input logic ez);
    a_s[0] = a; b_s[0] = b; cin_s[0] = cin; sub_s[0] = sub;
    iv_s[0] = 1'b1; or_s[0] = 1'b1;
    @(posedge clk); #1 iv_s[0] = 1'b0;
    repeat (LAT0 - 2) @(posedge clk);
    @(negedge clk);
    chk({nm, "_early"}, 32'(ov_s[0]), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({nm, "_valid"}, 32'(ov_s[0]), 32'd1);
    chk({nm, "_sum"},   32'(sum_x[0]), 32'(es));
    chk({nm, "_cout"},  32'(cout_x[0]), 32'(ec));
    chk({nm, "_ovf"},   32'(ovf_x[0]), 32'(eo));
    chk({nm, "_zero"},  32'(zero_x[0]), 32'(ez));
    @(posedge clk); #1;
  endtask

  initial begin : p_watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : p_drive
    int  sent, seen, stall, cyc;
    bit  pend;
    for (int k = 0; k < NI; k++) begin
      a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0; sub_s[k] = 1'b0;
      iv_s[k] = 1'b0; or_s[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_out_valid", 32'(ov_s[k]), 32'd0);
      chk("rst_in_ready",  32'(ir_s[k]), 32'd1);
      chk("rst_sum",       32'(sum_x[k]), 32'd0);
      chk("rst_flags",     32'({cout_x[k], ovf_x[k], zero_x[k]}), 32'd0);
    end
    @(posedge clk); #1;

    run_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_borrow",16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
`ifdef KS_ADDSUB_SAT_EN
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    run_one("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif

    // Eight back-to-back beats, then a four-cycle stall after the first result.
    sent = 0; seen = 0; stall = -1; cyc = 0; pend = 1'b0;
    while ((sent < 8 || seen < 8) && cyc < 80) begin
      if (!pend && sent < 8) begin
        a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
        cin_s[0] = 1'($urandom); sub_s[0] = 1'($urandom);
        pend = 1'b1;
      end
      iv_s[0] = pend;
      or_s[0] = !(stall > 0);
      @(negedge clk);
      if (stall == 0 && seen >= 1 && seen < 8) chk("stream_gap", 32'(ov_s[0]), 32'd1);
      if (stall > 0) chk("stall_in_ready", 32'(ir_s[0]), 32'd0);
      if (pend && ir_s[0]) begin pend = 1'b0; sent++; end
      if (ov_s[0] && or_s[0]) seen++;
      if (stall > 0) stall--;
      else if (stall < 0 && ov_s[0]) stall = 4;
      cyc++;
      @(posedge clk); #1;
    end
    iv_s[0] = 1'b0; or_s[0] = 1'b1;
    chk("stream_results", 32'(seen), 32'd8);

    // Reset with three beats in flight: none of them may emerge.
    for (int j = 0; j < 3; j++) begin
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); iv_s[0] = 1'b1;
      @(posedge clk); #1;
    end
    iv_s[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < LAT0 + 3; j++) begin
      @(negedge clk);
      chk("post_reset_quiet", 32'(ov_s[0]), 32'd0);
      @(posedge clk); #1;
    end
    run_one("after_reset", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0);

    // Random traffic on all widths with random bubbles and backpressure.
    for (int c = 0; c < NCYC; c++) begin
      for (int k = 0; k < NI; k++) begin
        iv_s[k]  = ($urandom_range(0, 99) < 70);
        or_s[k]  = ($urandom_range(0, 99) < 75);
        cin_s[k] = 1'($urandom);
        sub_s[k] = 1'($urandom);
        a_s[k]   = 16'($urandom) & mask16(k);
        b_s[k]   = 16'($urandom) & mask16(k);
        if ($urandom_range(0, 7) == 0) a_s[k] = mask16(k) >> 1;
        if ($urandom_range(0, 7) == 0) b_s[k] = mask16(k) & ~(mask16(k) >> 1);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < NI; k++) begin iv_s[k] = 1'b0; or_s[k] = 1'b1; end
    repeat (20) @(posedge clk);
    #1 end_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
